sprite_rom_arbiter: RTL

Shares one synchronous sprite ROM and its palette index stream between several pixel requesters, such as tank, bullet and brick renderers. The ROM is clocked on the falling edge of vga_clk. Each cycle the block grants at most one requester, drives the winner's address to the ROM, and returns the fetched palette index to that requester one cycle later with a one-hot valid. Arbitration is round-robin, with an optional fixed top priority for requester 0, which is the on-screen pixel path.

---
 rtl/sprite_rom_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one falling-edge sprite ROM between pixel requesters.
// Requester 0 can optionally be given fixed top priority.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int PRIO0   = 1
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic                      busy
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam bit USE_P0 = (PRIO0 != 0);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;
  logic [PTR_W:0]   nxt_sum;

  // Winner: priority requester 0 first, else wrap-around scan starting at ptr.
  // With priority enabled, index 0 never takes part in the round-robin scan.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (USE_P0 && req[0]) begin
      win_found = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
        if (scan_sum >= (PTR_W+1)'(NUM_REQ))
          scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
        scan_idx = scan_sum[PTR_W-1:0];
        if (!win_found && req[scan_idx] && !(USE_P0 && scan_idx == '0)) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end
  end

  // Pointer only advances on round-robin grants; in priority mode it skips 0.
  always_comb begin
    ptr_d   = ptr_q;
    nxt_sum = {1'b0, win_idx} + (PTR_W+1)'(1);
    if (nxt_sum >= (PTR_W+1)'(NUM_REQ))
      nxt_sum = '0;
    if (USE_P0 && nxt_sum == '0)
      nxt_sum = (PTR_W+1)'(1);
    if (win_found && !(USE_P0 && win_idx == '0))
      ptr_d = nxt_sum[PTR_W-1:0];
  end

  always_comb begin
    gnt_d         = '0;
    rom_address_d = rom_address_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && win_idx == PTR_W'(i)) begin
        gnt_d[i]      = 1'b1;
        rom_address_d = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    rd_valid_d = gnt_q;
    rd_data_d  = (|gnt_q) ? rom_q : rd_data_q;
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      ptr_q         <= '0;
      gnt_q         <= '0;
      rom_address_q <= '0;
      rd_valid_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      rom_address_q <= rom_address_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rom_address = rom_address_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign busy        = (|gnt_q) | (|rd_valid_q);

endmodule
